// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - one fully connected layer on a single time-multiplexed MAC
// Optional feature macro: LAYER_SAT_EN (saturating narrow of the pre-activation).
module nn_layer_sequencer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int W     = 8,
    parameter int FRAC  = 4,
    parameter int ACC_W = 20,
    localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WAW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [IW-1:0]  in_addr,
    input  logic [W-1:0]   in_data,
    output logic [WAW-1:0] w_addr,
    input  logic [W-1:0]   w_data,
    output logic [JW-1:0]  b_addr,
    input  logic [W-1:0]   b_data,
    output logic           rd_en,
    output logic [W-1:0]   act_z,
    input  logic [W-1:0]   act_a,
    output logic           out_we,
    output logic [JW-1:0]  out_addr,
    output logic [W-1:0]   out_data
);

`ifdef LAYER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_ACT, S_DONE} state_t;

    state_t                  state;
    logic [IW-1:0]           i;
    logic [JW-1:0]           j;
    logic                    v;
    logic signed [ACC_W-1:0] acc;
    logic [W-1:0]            z_reg;

    logic signed [2*W-1:0]   prod_sh;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] b_ext;
    logic signed [ACC_W-1:0] sum;
    logic [ACC_W-W:0]        sum_hi;
    logic                    ovf;
    logic [W-1:0]            sat_val;
    logic [W-1:0]            narrowed;

    // Arithmetic shift of the full-width product floors toward minus infinity.
    assign prod_sh  = ($signed(in_data) * $signed(w_data)) >>> FRAC;
    assign prod_ext = ACC_W'(prod_sh);
    assign b_ext    = ACC_W'($signed(b_data));
    assign sum      = acc + prod_ext + b_ext;

    // Out of range when the bits above the W-bit sign position disagree.
    assign sum_hi   = sum[ACC_W-1:W-1];
    assign ovf      = !((&sum_hi) || !(|sum_hi));
    assign sat_val  = sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign narrowed = (SAT_EN && ovf) ? sat_val : sum[W-1:0];

    assign in_addr  = i;
    assign w_addr   = WAW'(int'(j) * N_IN + int'(i));
    assign b_addr   = j;
    assign out_addr = j;
    assign act_z    = z_reg;
    assign out_data = out_we ? act_a : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            i      <= '0;
            j      <= '0;
            v      <= 1'b0;
            acc    <= '0;
            z_reg  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_en  <= 1'b0;
            out_we <= 1'b0;
        end else begin
            v <= (state == S_RUN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        i     <= '0;
                        j     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Data returning now belongs to the previous cycle's issue.
                    if (v) acc <= acc + prod_ext;
                    if (i == IW'(N_IN - 1)) begin
                        state <= S_DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_DRAIN: begin
                    z_reg  <= narrowed;
                    acc    <= '0;
                    out_we <= 1'b1;
                    state  <= S_ACT;
                end
                S_ACT: begin
                    out_we <= 1'b0;
                    if (j == JW'(N_OUT - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        j     <= j + 1'b1;
                        i     <= '0;
                        rd_en <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - self-checking bench for nn_layer_sequencer
module tb_nn_layer_sequencer;
    localparam int N_IN  = 2;
    localparam int N_OUT = 2;
    localparam int W     = 8;
    localparam int FRAC  = 4;
    localparam int ACC_W = 20;
    localparam int LAT   = N_OUT * (N_IN + 2) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, rd_en, out_we;
    logic [0:0] in_addr, b_addr, out_addr;
    logic [1:0] w_addr;
    logic [7:0] in_data, w_data, b_data, act_z, act_a, out_data;

    int tests = 0;
    int fails = 0;
    int in_mem[N_IN];
    int w_mem[N_IN*N_OUT];
    int b_mem[N_OUT];
    bit relu = 1'b0;

    int         wr_k[$];
    int         wr_a[$];
    logic [7:0] wr_d[$];
    int         done_k[$];
    bit         busy_q[$];

    nn_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .rd_en(rd_en), .act_z(act_z), .act_a(act_a),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memories; activation is identity or ReLU.
    always @(posedge clk) begin
        if (rd_en) begin
            in_data <= 8'(in_mem[in_addr]);
            w_data  <= 8'(w_mem[w_addr]);
        end
        b_data <= 8'(b_mem[b_addr]);
    end
    assign act_a = (relu && act_z[7]) ? 8'd0 : act_z;

    function automatic logic [7:0] model(input int j);
        int s = b_mem[j];
        logic [7:0] r;
        for (int k = 0; k < N_IN; k++) s += (in_mem[k] * w_mem[j*N_IN+k]) >>> FRAC;
`ifdef LAYER_SAT_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        r = 8'(s);
        if (relu && r[7]) r = 8'd0;
        return r;
    endfunction

    task automatic load(input int i0, i1, w00, w01, w10, w11, b0, b1);
        in_mem[0] = i0; in_mem[1] = i1;
        w_mem[0] = w00; w_mem[1] = w01; w_mem[2] = w10; w_mem[3] = w11;
        b_mem[0] = b0; b_mem[1] = b1;
    endtask

    task automatic run_pass(input int ncyc, input int pulse_at, input bit hold);
        wr_k.delete(); wr_a.delete(); wr_d.delete(); done_k.delete(); busy_q.delete();
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = (hold && k < ncyc - 1) || (k == pulse_at);
            if (out_we) begin
                wr_k.push_back(k); wr_a.push_back(int'(out_addr)); wr_d.push_back(out_data);
            end
            if (done) done_k.push_back(k);
            busy_q.push_back(busy);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({busy, done, rd_en, out_we} !== 4'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b required 0000", {busy, done, rd_en, out_we});
        end
        tests++;
        if ({in_addr, w_addr, b_addr, out_addr, act_z, out_data} !== '0) begin
            fails++; $display("FAIL reset_data: got %h required 0", {in_addr, w_addr, b_addr, out_addr, act_z, out_data});
        end
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, out_we} !== 3'b0) begin
            fails++; $display("FAIL idle_after_reset: got %b required 000", {busy, done, out_we});
        end
    endtask

    task automatic test_pass(input string name, input int pulse_at);
        logic [7:0] e;
        run_pass(LAT + 3, pulse_at, 1'b0);
        tests++;
        if (wr_k.size() != N_OUT) begin
            fails++; $display("FAIL %s write_count: got %0d required %0d", name, wr_k.size(), N_OUT);
        end
        for (int j = 0; j < N_OUT && j < wr_k.size(); j++) begin
            e = model(j);
            tests++;
            if (wr_k[j] != (j + 1) * (N_IN + 2) || wr_a[j] != j || wr_d[j] !== e) begin
                fails++;
                $display("FAIL %s write%0d: got cycle %0d addr %0d data %0d required cycle %0d addr %0d data %0d",
                         name, j, wr_k[j], wr_a[j], $signed(wr_d[j]), (j + 1) * (N_IN + 2), j, $signed(e));
            end
        end
        tests++;
        if (done_k.size() != 1 || done_k[0] != LAT) begin
            fails++; $display("FAIL %s done: got %0d pulses (first %0d) required 1 at %0d",
                              name, done_k.size(), done_k.size() > 0 ? done_k[0] : -1, LAT);
        end
        for (int k = 1; k <= LAT + 3; k++) begin
            tests++;
            if (busy_q[k-1] !== (k <= LAT)) begin
                fails++; $display("FAIL %s busy@%0d: got %0d required %0d", name, k, busy_q[k-1], k <= LAT);
            end
        end
    endtask

    task automatic test_start_ignored;
        load(16, 32, 7, 6, 7, 6, -15, 5);
        test_pass("start_ignored", 3);
    endtask

    task automatic test_mid_reset;
        int seen = 0;
        load(16, 32, 7, 6, 7, 6, -15, 5);
        @(negedge clk); start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        tests++;
        if ({busy, rd_en} !== 2'b11) begin
            fails++; $display("FAIL mid_reset_running: got %b required 11", {busy, rd_en});
        end
        #1 rst = 1'b0;
        #1;
        tests++;
        if ({busy, rd_en, out_we, done} !== 4'b0) begin
            fails++; $display("FAIL mid_reset_drop: got %b required 0000", {busy, rd_en, out_we, done});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b1;
            if (out_we || done) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL mid_reset_quiet: got %0d write/done cycles required 0", seen);
        end
        test_pass("after_reset", -1);
    endtask

    task automatic test_back_to_back;
        int exp_k[4] = '{4, 8, 14, 18};
        load(16, 32, 7, 6, 7, 6, -15, 5);
        run_pass(20, -1, 1'b1);
        tests++;
        if (wr_k.size() != 4) begin
            fails++; $display("FAIL b2b write_count: got %0d required 4", wr_k.size());
        end
        for (int n = 0; n < 4 && n < wr_k.size(); n++) begin
            tests++;
            if (wr_k[n] != exp_k[n] || wr_a[n] != n % 2 || wr_d[n] !== model(n % 2)) begin
                fails++; $display("FAIL b2b write%0d: got cycle %0d addr %0d data %0d required cycle %0d addr %0d",
                                  n, wr_k[n], wr_a[n], $signed(wr_d[n]), exp_k[n], n % 2);
            end
        end
        tests++;
        if (done_k.size() != 2 || done_k[0] != 9 || done_k[1] != 19) begin
            fails++; $display("FAIL b2b done: got %0d pulses required 2 at 9 and 19", done_k.size());
        end
        for (int k = 1; k <= 20; k++) begin
            tests++;
            if (busy_q[k-1] !== ((k <= 9) || (k >= 11 && k <= 19))) begin
                fails++; $display("FAIL b2b busy@%0d: got %0d", k, busy_q[k-1]);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            foreach (in_mem[k]) in_mem[k] = int'($urandom_range(0, 255)) - 128;
            foreach (w_mem[k])  w_mem[k]  = int'($urandom_range(0, 255)) - 128;
            foreach (b_mem[k])  b_mem[k]  = int'($urandom_range(0, 255)) - 128;
            relu = 1'($urandom_range(0, 1));
            test_pass("random", -1);
        end
        relu = 1'b0;
    endtask

    initial begin
        test_reset;
        load(16, 32, 7, 6, 7, 6, -15, 5);
        test_pass("basic", -1);
        load(127, 127, 127, 127, 127, 127, 5, 5);
        test_pass("saturation", -1);
        load(-16, 0, 7, 0, 7, 0, 0, 0);
        test_pass("neg_round_a", -1);
        load(-1, 0, 1, 0, 1, 0, 0, 0);
        test_pass("neg_round_b", -1);
        test_start_ignored;
        test_mid_reset;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
